// File: rtl/mem_ls_pkg.sv
// Shared definitions for the core-side PRAM load/store controller.
//   - access size encodings (SZ_*)
//   - response error codes (ERR_*)
//   - controller FSM state enum
//   - alignment helper used by the request checker
package mem_ls_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_ALIGN   = 2'b01;
   localparam logic [1:0] ERR_RANGE   = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_e;

   // Size 11 is illegal and reported the same way as a misaligned address.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      return (size == 2'b11) ||
             ((size == SZ_HALF) && off[0]) ||
             ((size == SZ_WORD) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/mem_ls_align.sv
// Combinational data formatting between the pipeline and the PRAM.
//   size        : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   is_unsigned : zero-extend loads instead of sign-extending
//   off         : byte offset addr[1:0]
//   wdata       : right-justified store data
//   pram_rdata  : raw 32-bit word read from the PRAM
//   w_rep       : store data replicated across all candidate byte lanes
//   rdata_ext   : extracted and extended load data
module mem_ls_align
   import mem_ls_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] pram_rdata,
   output logic [31:0] w_rep,
   output logic [31:0] rdata_ext
);

   logic [15:0] shifted;

   always_comb begin
      // Only the low 16 bits of the lane-aligned word are ever needed.
      shifted   = 16'(pram_rdata >> {off, 3'b000});
      w_rep     = wdata;
      rdata_ext = pram_rdata;
      case (size)
         SZ_BYTE: begin
            w_rep     = {4{wdata[7:0]}};
            rdata_ext = is_unsigned ? {24'h0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
         end
         SZ_HALF: begin
            w_rep     = {2{wdata[15:0]}};
            rdata_ext = is_unsigned ? {16'h0, shifted}
                                    : {{16{shifted[15]}}, shifted};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_ls_ctrl.sv
// Load/store controller between the core pipeline and the 4-bank PRAM.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_*                      : pipeline request (valid/ready)
//   resp_valid/rdata/err       : one-cycle response, data/err held until next response
//   wen, mem_addr, w_in,
//   access_size, mem_ctrl_ls   : PRAM access request
//   pram_data_o, load_done,
//   store_done                 : PRAM read data and completions
//   dbg_state                  : current FSM state for observation
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, so exactly one request is in flight.
module mem_ls_ctrl
   import mem_ls_pkg::*;
#(
   parameter int ADDR_W      = 14,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic        wen,
   output logic [15:0] mem_addr,
   output logic [31:0] w_in,
   output logic [1:0]  access_size,
   output logic        mem_ctrl_ls,
   input  logic [31:0] pram_data_o,
   input  logic        load_done,
   input  logic        store_done,
   output logic [1:0]  dbg_state
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   state_e              state_q, state_d;
   logic                store_q, store_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [1:0]          err_q, err_d;

   logic        bad_align, bad_range, done_hit, cnt_expired;
   logic [31:0] load_ext;

   assign bad_align   = is_misaligned(req_size, req_addr[1:0]);
   assign bad_range   = (req_addr >> ADDR_W) != 32'd0;
   // Only the done matching the registered direction completes the access.
   assign done_hit    = store_q ? store_done : load_done;
   assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT_CYC));

   mem_ls_align u_align (
      .size        (size_q),
      .is_unsigned (uns_q),
      .off         (addr_q[1:0]),
      .wdata       (wdata_q),
      .pram_rdata  (pram_data_o),
      .w_rep       (w_in),
      .rdata_ext   (load_ext)
   );

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:
            if (req_valid) state_d = (bad_align || bad_range) ? ST_RESP : ST_ACCESS;
         ST_ACCESS:
            if (done_hit || cnt_expired) state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      req_ready   = (state_q == ST_IDLE);
      mem_ctrl_ls = (state_q == ST_ACCESS);
      wen         = (state_q == ST_ACCESS) && store_q;
      resp_valid  = (state_q == ST_RESP);
      dbg_state   = state_q;
   end

   // Request capture, watchdog and response data
   always_comb begin
      store_d = store_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE:
            if (req_valid) begin
               store_d = req_store;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr[ADDR_W-1:0];
               wdata_d = req_wdata;
               cnt_d   = '0;
               if (bad_align) begin
                  err_d   = ERR_ALIGN;
                  rdata_d = '0;
               end else if (bad_range) begin
                  err_d   = ERR_RANGE;
                  rdata_d = '0;
               end
            end
         ST_ACCESS:
            if (done_hit) begin
               err_d   = ERR_OK;
               rdata_d = store_q ? 32'd0 : load_ext;
            end else if (cnt_expired) begin
               err_d   = ERR_TIMEOUT;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         store_q <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= ERR_OK;
      end else begin
         store_q <= store_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign mem_addr    = 16'(addr_q);
   assign access_size = size_q;
   assign resp_rdata  = rdata_q;
   assign resp_err    = err_q;

endmodule
